// File: rtl/pw_trigger_seq_pkg.sv
// Shared types and constants for the multi-pulse trigger sequencer.
// State encodings and the width of the missed-match counter live here.
package pw_trigger_seq_pkg;

    typedef enum logic [1:0] {
        PW_TSEQ_IDLE  = 2'd0,
        PW_TSEQ_DELAY = 2'd1,
        PW_TSEQ_PULSE = 2'd2
    } pw_tseq_state_e;

    localparam int PW_TSEQ_MISSED_WIDTH = 8;
    localparam logic [PW_TSEQ_MISSED_WIDTH-1:0] PW_TSEQ_MISSED_MAX = '1;

endpackage

// File: rtl/pw_loadable_downcounter.sv
// Loadable down-counter that holds at zero; terminal flags a zero count.
// A counter held at zero can never wrap, so every phase is guaranteed to end.
module pw_loadable_downcounter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: on an armed match, emits up to pNUM_PULSES
// pulses on O_trigger, each with its own delay and width.
module pw_trigger_seq
    import pw_trigger_seq_pkg::*;
#(
    parameter int pNUM_PULSES  = 8,
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pIDX_WIDTH   = 4
) (
    input  logic                                fe_clk,
    input  logic                                reset_i,
    input  logic                                I_arm,
    input  logic                                I_match,
    input  logic [pIDX_WIDTH:0]                 I_num_pulses,
    input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0] I_delays,
    input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0] I_widths,
    output logic                                O_trigger,
    output logic                                O_busy,
    output logic                                O_done,
    output logic [pIDX_WIDTH-1:0]               O_pulse_idx,
    output logic [PW_TSEQ_MISSED_WIDTH-1:0]     O_missed
);

    localparam logic [pIDX_WIDTH:0] MAX_PULSES = (pIDX_WIDTH+1)'(pNUM_PULSES);

    pw_tseq_state_e state_q, state_d;
    logic [pIDX_WIDTH-1:0] idx_q, idx_d;
    logic [pIDX_WIDTH:0] idx_plus, num_clamped, delay_sel_idx;
    logic last_pulse;

    logic [pDELAY_WIDTH-1:0] sel_delay, dly_load_val;
    logic [pWIDTH_WIDTH-1:0] sel_width, wid_load_val;
    logic dly_load, wid_load, dly_en, wid_en, dly_term, wid_term;

    logic trigger_q, busy_q, done_q, arm_q;
    logic trigger_d, busy_d, done_d;
    logic [PW_TSEQ_MISSED_WIDTH-1:0] missed_q, missed_d;

    // idx_plus is one bit wider so idx+1 never wraps when pNUM_PULSES is 2**pIDX_WIDTH.
    assign idx_plus      = {1'b0, idx_q} + (pIDX_WIDTH+1)'(1);
    assign num_clamped   = (I_num_pulses > MAX_PULSES) ? MAX_PULSES : I_num_pulses;
    assign last_pulse    = !(idx_plus < num_clamped);
    assign delay_sel_idx = (state_q == PW_TSEQ_PULSE) ? idx_plus : {1'b0, idx_q};

    always_comb begin
        sel_delay = '0;
        sel_width = '0;
        for (int k = 0; k < pNUM_PULSES; k++) begin
            if (int'(delay_sel_idx) == k) begin
                sel_delay = I_delays[k*pDELAY_WIDTH +: pDELAY_WIDTH];
            end
            if (int'(idx_q) == k) begin
                sel_width = I_widths[k*pWIDTH_WIDTH +: pWIDTH_WIDTH];
            end
        end
    end

    // Each phase lasts (loaded value + 1) cycles. Pulse 0 has no separating gap,
    // so its delay is loaded as d0-1, and d0 == 0 goes straight to PULSE.
    assign wid_load_val = (sel_width == '0) ? '0 : sel_width - pWIDTH_WIDTH'(1);
    assign dly_en       = (state_q == PW_TSEQ_DELAY);
    assign wid_en       = (state_q == PW_TSEQ_PULSE);

    always_ff @(posedge fe_clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= PW_TSEQ_IDLE;
            idx_q     <= '0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            missed_q  <= '0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            missed_q  <= missed_d;
            arm_q     <= I_arm;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dly_load     = 1'b0;
        dly_load_val = '0;
        wid_load     = 1'b0;
        if (!I_arm) begin
            state_d = PW_TSEQ_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                PW_TSEQ_IDLE: begin
                    if (I_match && (I_num_pulses != '0) && !done_q) begin
                        idx_d = '0;
                        if (sel_delay == '0) begin
                            state_d  = PW_TSEQ_PULSE;
                            wid_load = 1'b1;
                        end else begin
                            state_d      = PW_TSEQ_DELAY;
                            dly_load     = 1'b1;
                            dly_load_val = sel_delay - pDELAY_WIDTH'(1);
                        end
                    end
                end
                PW_TSEQ_DELAY: begin
                    if (dly_term) begin
                        state_d  = PW_TSEQ_PULSE;
                        wid_load = 1'b1;
                    end
                end
                PW_TSEQ_PULSE: begin
                    if (wid_term) begin
                        if (last_pulse) begin
                            state_d = PW_TSEQ_IDLE;
                            idx_d   = '0;
                        end else begin
                            state_d      = PW_TSEQ_DELAY;
                            idx_d        = idx_plus[pIDX_WIDTH-1:0];
                            dly_load     = 1'b1;
                            dly_load_val = sel_delay;
                        end
                    end
                end
                default: begin
                    state_d = PW_TSEQ_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Registered outputs are derived from the upcoming state so they line up with it.
    always_comb begin
        trigger_d = (state_d == PW_TSEQ_PULSE);
        busy_d    = (state_d != PW_TSEQ_IDLE);
        done_d    = I_arm && (state_q == PW_TSEQ_PULSE) && wid_term && last_pulse;
        missed_d  = missed_q;
        if (I_arm && !arm_q) begin
            missed_d = '0;
        end else if (I_match && (busy_q || done_q) && (missed_q != PW_TSEQ_MISSED_MAX)) begin
            missed_d = missed_q + PW_TSEQ_MISSED_WIDTH'(1);
        end
    end

    pw_loadable_downcounter #(.WIDTH(pDELAY_WIDTH)) u_delay_cnt (
        .clk        (fe_clk),
        .rst_n      (reset_i),
        .load       (dly_load),
        .load_value (dly_load_val),
        .enable     (dly_en),
        .terminal   (dly_term)
    );

    pw_loadable_downcounter #(.WIDTH(pWIDTH_WIDTH)) u_width_cnt (
        .clk        (fe_clk),
        .rst_n      (reset_i),
        .load       (wid_load),
        .load_value (wid_load_val),
        .enable     (wid_en),
        .terminal   (wid_term)
    );

    assign O_trigger   = trigger_q;
    assign O_busy      = busy_q;
    assign O_done      = done_q;
    assign O_pulse_idx = idx_q;
    assign O_missed    = missed_q;

endmodule

// File: doc/pw_trigger_seq.md
Name: pw_trigger_seq

Overview:
Multi-pulse trigger sequencer, the parametrised successor of the single delay/width trigger generator.
- On a qualified pattern match it emits a programmable train of up to pNUM_PULSES pulses on O_trigger. Each pulse has its own delay and width.
- Sits between pw_pattern_matcher (I_match) and the CW/MCX trigger outputs.
- Configuration comes from reg_pw. Status (busy, pulse index, missed-match count) goes back to reg_pw.

Parameters:
pNUM_PULSES, 8, maximum pulses per sequence (1..16)
pDELAY_WIDTH, 20, bits per per-pulse delay field
pWIDTH_WIDTH, 17, bits per per-pulse width field
pIDX_WIDTH, 4, pulse index/count field width; must satisfy 2**pIDX_WIDTH >= pNUM_PULSES

Ports:
fe_clk  input  1  sole clock; all logic on rising edge
reset_i  input  1  asynchronous, active-low reset
I_arm  input  1  sequencer enabled while high
I_match  input  1  single-cycle trigger-match strobe
I_num_pulses  input  pIDX_WIDTH+1  pulses per sequence; 0 disables; values >pNUM_PULSES clamp to pNUM_PULSES
I_delays  input  pNUM_PULSES*pDELAY_WIDTH  delay k in bits [k*pDELAY_WIDTH +: pDELAY_WIDTH]
I_widths  input  pNUM_PULSES*pWIDTH_WIDTH  width k in bits [k*pWIDTH_WIDTH +: pWIDTH_WIDTH]
O_trigger  output  1  registered trigger output
O_busy  output  1  sequence in progress
O_done  output  1  one-cycle strobe at normal sequence completion
O_pulse_idx  output  pIDX_WIDTH  index of the pulse currently being delayed or driven
O_missed  output  8  saturating count of matches ignored while busy

Behaviour:
- Reset (reset_i low, asynchronous): all outputs 0, state IDLE, counters 0.
- States: IDLE, DELAY, PULSE. All outputs are registered.
- IDLE -> DELAY when I_arm & I_match & (I_num_pulses != 0).
  - Load delay counter with delay[0]; O_pulse_idx = 0; O_busy = 1.
  - If I_num_pulses is 0, the match is ignored and nothing changes.
- Pulse 0 timing: with the match sampled at edge t, O_trigger is high from cycle t+1+d0 for exactly w0 cycles.
- Pulse k>0 timing: O_trigger is low for exactly dk+1 cycles after pulse k-1 ends, then high for wk cycles. Consecutive pulses therefore never merge.
- Width 0 is treated as width 1.
- DELAY: down-count; at terminal count go to PULSE and load the width counter.
- PULSE: at terminal count:
  - If idx+1 < clamped count: idx++, load delay[idx], go to DELAY.
  - Otherwise go to IDLE. O_trigger and O_busy fall, and O_done pulses for 1 cycle, on the cycle after the last high cycle.
- Counter arithmetic is unsigned. Maximum delay 2^pDELAY_WIDTH-1 and maximum width 2^pWIDTH_WIDTH-1 must work with no wrap.
- I_match while O_busy (or in the completion cycle): ignored; O_missed increments, saturating at 255.
- O_missed clears to 0 on a rising edge of I_arm.
- I_arm low in any state: abort on the next edge. Return to IDLE; O_trigger=0, O_busy=0, O_done stays 0; O_pulse_idx resets to 0.
- I_arm and I_match high in the same cycle as an arm rising edge: the match is accepted.
- Configuration inputs (I_delays, I_widths, I_num_pulses) are read live and must be static while O_busy. Behaviour under mid-sequence changes is undefined but must not deadlock; each counter always reaches terminal count.

Decomposition:
- State encodings (IDLE/DELAY/PULSE) and O_missed width go in defines.v as `PW_TSEQ_* constants.
- One natural sub-module: pw_loadable_downcounter (parameter WIDTH; load, enable, terminal-count flag).
  - Instantiated twice: once for delay, once for width.

Test Plan:
1. Single pulse: num=1, d0=5, w0=3, match at t=10 -> O_trigger high cycles 16..18; O_busy high 11..18; O_done at 19; O_missed=0.
2. Three-pulse train: num=3, d={2,0,4}, w={1,2,3}, match at t=0.
   - O_trigger high at 3, 5..6, 12..14.
   - O_pulse_idx 0/1/2 in step.
   - O_done at 15.
3. Missed matches and saturation:
   - Matches at t+2 and t+4 during a sequence -> O_missed=2; sequence timing unchanged.
   - 300 matches while busy -> O_missed=255.
   - Re-arm (I_arm 0→1) -> O_missed=0.
4. Abort: drop I_arm mid-PULSE of pulse 1 -> next cycle O_trigger=0, O_busy=0, O_done never asserts; a fresh match after re-arm restarts from pulse 0.
5. Boundaries:
   - num=0 -> match ignored.
   - num=15 with pNUM_PULSES=8 -> exactly 8 pulses.
   - w=0 -> 1-cycle pulse.
   - d0=2^20-1 -> O_trigger rises exactly 2^20 cycles after match.
6. Asynchronous reset: assert reset_i low mid-DELAY between clock edges -> outputs 0 immediately. After release, a match yields a correct pulse 0.
